mem_bus_ctrl: RTL and testbench

Multi-cycle MEM-stage bus controller that replaces the single-cycle data-memory path between `ex_mem` and `mem_wb`. It decodes the EX/MEM address into SRAM (Ram1) or memory-mapped UART space, sequences the shared Ram1 data bus with a state machine, and raises `MemStall` so the upstream stages hold while an access is in flight.

---
 rtl/mem_bus_pkg.sv | 32 +++
 rtl/uart_strobe.sv | 82 ++++++++
 rtl/mem_bus_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - state encoding, UART register map and status layout for mem_bus_ctrl
package mem_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SRAM_RD,
        ST_SRAM_WR,
        ST_UART_RD,
        ST_UART_WR,
        ST_UART_TXW,
        ST_DONE
    } mem_state_t;

    localparam logic [15:0] UART_DATA_ADDR_DEF = 16'hBF00;
    localparam logic [15:0] UART_STAT_ADDR_DEF = 16'hBF01;

    localparam int STAT_TX_RDY_BIT = 0;
    localparam int STAT_RX_RDY_BIT = 1;
    localparam int STAT_ERR_BIT    = 2;

    function automatic logic [15:0] status_word(input logic err,
                                                input logic rx_rdy,
                                                input logic tx_rdy);
        logic [15:0] w;
        w                  = '0;
        w[STAT_ERR_BIT]    = err;
        w[STAT_RX_RDY_BIT] = rx_rdy;
        w[STAT_TX_RDY_BIT] = tx_rdy;
        return w;
    endfunction

endpackage

// File: rtl/uart_strobe.sv
// rtl/uart_strobe.sv - UART rdn/wrn pulse sequencing and TX-ready wait; MEM_BUS_TIMEOUT_EN adds a TX timeout
module uart_strobe
    import mem_bus_pkg::*;
#(
    parameter logic [15:0] TX_TIMEOUT = 16'd1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  mem_state_t state_i,
    input  logic       data_ready,
    input  logic       tbre,
    input  logic       tsre,
    output logic       rdn,
    output logic       wrn,
    output logic       rd_last,
    output logic       tx_done,
    output logic       err
);

    // 0: waiting for data_ready, 1/2: the two rdn-low cycles
    logic [1:0] rd_phase_q, rd_phase_d;
    logic       tx_ready;

    assign tx_ready = tbre & tsre;

`ifdef MEM_BUS_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = (TX_TIMEOUT == 16'd0) ? 16'd0 : TX_TIMEOUT - 16'd1;

    logic [15:0] tmo_q, tmo_d;
    logic        err_q, err_d;
    logic        tmo_hit;
`else
    logic unused_tmo;
    assign unused_tmo = ^TX_TIMEOUT;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_phase_q <= 2'd0;
`ifdef MEM_BUS_TIMEOUT_EN
            tmo_q      <= 16'd0;
            err_q      <= 1'b0;
`endif
        end else begin
            rd_phase_q <= rd_phase_d;
`ifdef MEM_BUS_TIMEOUT_EN
            tmo_q      <= tmo_d;
            err_q      <= err_d;
`endif
        end
    end

    always_comb begin
        rd_phase_d = 2'd0;
        if (state_i == ST_UART_RD) begin
            if (rd_phase_q == 2'd1) begin
                rd_phase_d = 2'd2;
            end else if (rd_phase_q == 2'd0 && data_ready) begin
                rd_phase_d = 2'd1;
            end
        end
    end

`ifdef MEM_BUS_TIMEOUT_EN
    always_comb begin
        tmo_hit = (state_i == ST_UART_TXW) && (tmo_q == TMO_LAST);
        tmo_d   = (state_i == ST_UART_TXW) ? tmo_q + 16'd1 : 16'd0;
        err_d   = err_q | (tmo_hit & ~tx_ready);
    end

    assign tx_done = tx_ready | tmo_hit;
    assign err     = err_q;
`else
    assign tx_done = tx_ready;
    assign err     = 1'b0;
`endif

    assign rdn     = !((state_i == ST_UART_RD) && (rd_phase_q != 2'd0));
    assign wrn     = !(state_i == ST_UART_WR);
    assign rd_last = (state_i == ST_UART_RD) && (rd_phase_q == 2'd2);

endmodule

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - multi-cycle MEM-stage SRAM/UART bus controller; MEM_BUS_TIMEOUT_EN enables TX timeout and err
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int unsigned SRAM_WAIT      = 1,
    parameter logic [15:0] UART_DATA_ADDR = UART_DATA_ADDR_DEF,
    parameter logic [15:0] UART_STAT_ADDR = UART_STAT_ADDR_DEF,
    parameter logic [15:0] TX_TIMEOUT     = 16'd1000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [15:0] Result2,
    input  logic [15:0] DataIn2,
    input  logic        MemWrite2,
    input  logic        MemRead2,
    input  logic        data_ready,
    input  logic        tbre,
    input  logic        tsre,
    output logic [15:0] DataOut2,
    output logic        MemStall,
    output logic        Ram1_EN,
    output logic        Ram1_OE,
    output logic        Ram1_WE,
    output logic [17:0] Ram1_address,
    inout  wire  [15:0] Ram1_data,
    output logic        rdn,
    output logic        wrn
);

    localparam logic [2:0] WAIT_C = 3'(SRAM_WAIT);

    mem_state_t  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        hold_q, hold_d;
    logic [15:0] dout_q, dout_d;
    logic [17:0] addr_q, addr_d;

    logic        wr_req, rd_req, is_stat, is_data, stat_rd;
    logic        rd_last, tx_done, err;
    logic        drive;
    logic [15:0] bus_out;

    assign wr_req  = MemWrite2;
    assign rd_req  = MemRead2 & ~MemWrite2;
    assign is_stat = (Result2 == UART_STAT_ADDR);
    assign is_data = (Result2 == UART_DATA_ADDR);
    assign stat_rd = (state_q == ST_IDLE) && rd_req && is_stat;

    uart_strobe #(
        .TX_TIMEOUT (TX_TIMEOUT)
    ) u_uart_strobe (
        .clk        (Clk),
        .rst_n      (Rst),
        .state_i    (state_q),
        .data_ready (data_ready),
        .tbre       (tbre),
        .tsre       (tsre),
        .rdn        (rdn),
        .wrn        (wrn),
        .rd_last    (rd_last),
        .tx_done    (tx_done),
        .err        (err)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            hold_q  <= 1'b0;
            dout_q  <= 16'd0;
            addr_q  <= 18'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            dout_q  <= dout_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 3'd1;
        hold_d  = hold_q;
        dout_d  = dout_q;
        addr_d  = addr_q;
        unique case (state_q)
            ST_IDLE: begin
                hold_d = 1'b0;
                if (wr_req || (rd_req && !is_stat)) begin
                    addr_d = {2'b00, Result2};
                    if (is_data) begin
                        state_d = wr_req ? ST_UART_WR : ST_UART_RD;
                    end else if (is_stat) begin
                        // the status register is read-only; a store to it is dropped
                        state_d = ST_DONE;
                    end else begin
                        state_d = wr_req ? ST_SRAM_WR : ST_SRAM_RD;
                    end
                end
            end
            ST_SRAM_RD: begin
                if (cnt_q == WAIT_C) begin
                    dout_d  = Ram1_data;
                    state_d = ST_DONE;
                end
            end
            ST_SRAM_WR: begin
                if (hold_q) begin
                    state_d = ST_DONE;
                end else if (cnt_q == WAIT_C) begin
                    hold_d = 1'b1;
                end
            end
            ST_UART_RD: begin
                if (rd_last) begin
                    dout_d  = {8'h00, Ram1_data[7:0]};
                    state_d = ST_DONE;
                end
            end
            ST_UART_WR:  state_d = ST_UART_TXW;
            ST_UART_TXW: if (tx_done) state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        if (state_d != state_q) begin
            cnt_d = 3'd0;
        end
    end

    always_comb begin
        MemStall = 1'b0;
        Ram1_EN  = 1'b1;
        Ram1_OE  = 1'b1;
        Ram1_WE  = 1'b1;
        drive    = 1'b0;
        bus_out  = DataIn2;
        DataOut2 = dout_q;
        case (state_q)
            ST_IDLE: begin
                if (stat_rd) begin
                    DataOut2 = status_word(err, data_ready, tbre & tsre);
                end else begin
                    MemStall = wr_req | rd_req;
                end
            end
            ST_SRAM_RD: begin
                MemStall = 1'b1;
                Ram1_EN  = 1'b0;
                Ram1_OE  = 1'b0;
            end
            ST_SRAM_WR: begin
                MemStall = 1'b1;
                Ram1_EN  = 1'b0;
                Ram1_WE  = hold_q;
                drive    = 1'b1;
            end
            ST_UART_RD, ST_UART_TXW: begin
                MemStall = 1'b1;
            end
            ST_UART_WR: begin
                MemStall = 1'b1;
                drive    = 1'b1;
                bus_out  = {8'h00, DataIn2[7:0]};
            end
            default: begin
                MemStall = 1'b0;
            end
        endcase
    end

    assign Ram1_data    = drive ? bus_out : 16'hzzzz;
    assign Ram1_address = addr_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - randomized self-checking bench for mem_bus_ctrl with SRAM/UART models
module tb_mem_bus_ctrl;

    localparam int W = 1;

    logic        Clk, Rst;
    logic [15:0] Result2, DataIn2;
    logic        MemWrite2, MemRead2, data_ready, tbre, tsre;
    logic [15:0] DataOut2;
    logic        MemStall, Ram1_EN, Ram1_OE, Ram1_WE, rdn, wrn;
    logic [17:0] Ram1_address;
    wire  [15:0] Ram1_data;

    logic [15:0] sram    [0:255];
    logic [15:0] ref_mem [0:255];
    logic [15:0] written [$];
    logic [15:0] last_load;
    logic [7:0]  rx_byte, rx_hi;
    logic        tb_pull;
    logic        tb_en;
    logic [15:0] tb_bus;
    int          total, bad;
    int          kind;
    logic [15:0] a;

    mem_bus_ctrl #(.SRAM_WAIT(W)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Result2      (Result2),
        .DataIn2      (DataIn2),
        .MemWrite2    (MemWrite2),
        .MemRead2     (MemRead2),
        .data_ready   (data_ready),
        .tbre         (tbre),
        .tsre         (tsre),
        .DataOut2     (DataOut2),
        .MemStall     (MemStall),
        .Ram1_EN      (Ram1_EN),
        .Ram1_OE      (Ram1_OE),
        .Ram1_WE      (Ram1_WE),
        .Ram1_address (Ram1_address),
        .Ram1_data    (Ram1_data),
        .rdn          (rdn),
        .wrn          (wrn)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // external devices on the shared bus: SRAM, UART RX latch, and a known pattern to detect release
    always_comb begin
        tb_en  = 1'b0;
        tb_bus = 16'h0000;
        if (!Ram1_EN && !Ram1_OE) begin
            tb_en  = 1'b1;
            tb_bus = sram[Ram1_address[7:0]];
        end else if (!rdn) begin
            tb_en  = 1'b1;
            tb_bus = {rx_hi, rx_byte};
        end else if (tb_pull) begin
            tb_en  = 1'b1;
            tb_bus = 16'hA5C3;
        end
    end
    assign Ram1_data = tb_en ? tb_bus : 16'hzzzz;

    always @(posedge Clk) begin
        if (!Ram1_EN && !Ram1_WE) sram[Ram1_address[7:0]] <= Ram1_data;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic access(input logic wr, input logic rd, input logic [15:0] addr,
                          input logic [15:0] wdata, input int dr_delay, input int tx_low,
                          input logic [7:0] rx);
        int          cyc, stall, we_lo, oe_lo, rdn_lo, wrn_lo, wrn_cyc, rdn_last;
        logic        released, uart_d, stat;
        logic [15:0] dout;
        uart_d   = (addr == 16'hBF00);
        stat     = (addr == 16'hBF01);
        cyc      = 0;
        stall    = 0;
        we_lo    = 0;
        oe_lo    = 0;
        rdn_lo   = 0;
        wrn_lo   = 0;
        wrn_cyc  = -1;
        rdn_last = -1;
        released = 1'b0;
        dout     = 16'h0000;
        rx_byte  = rx;
        rx_hi    = 8'($urandom);
        @(posedge Clk); #1;
        MemWrite2 = wr;
        MemRead2  = rd;
        Result2   = addr;
        DataIn2   = wdata;
        if (uart_d && wr) tbre = (tx_low == 0);
        while (!released && cyc < 100) begin
            if (uart_d && !wr && cyc == dr_delay) data_ready = 1'b1;
            if (wrn_cyc >= 0 && cyc == wrn_cyc + 1 + tx_low) tbre = 1'b1;
            @(negedge Clk);
            if (!Ram1_WE) begin
                we_lo++;
                check_val("we_addr", 32'(Ram1_address), 32'({2'b00, addr}));
                check_val("we_data", 32'(Ram1_data), 32'(wdata));
            end
            if (!Ram1_OE) oe_lo++;
            if (!rdn) begin
                rdn_lo++;
                rdn_last = cyc;
                check_val("rdn_wait", 32'(data_ready), 32'd1);
            end
            if (!wrn) begin
                wrn_lo++;
                wrn_cyc = cyc;
                check_val("wrn_data", 32'(Ram1_data[7:0]), 32'(wdata[7:0]));
            end
            if (MemStall) begin
                stall++;
            end else begin
                released = 1'b1;
                dout     = DataOut2;
            end
            if (!released) begin
                @(posedge Clk); #1;
                cyc++;
            end
        end
        check_val("released", 32'(released), 32'd1);
        if (stat && !wr) begin
            check_val("stat_stall", stall, 0);
            check_val("stat_word", 32'(dout), 32'({14'b0, data_ready, tbre & tsre}));
        end else if (uart_d && wr) begin
            check_val("utx_stall", stall, 3 + tx_low);
            check_val("utx_wrn", wrn_lo, 1);
            check_val("utx_dout", 32'(dout), 32'(last_load));
        end else if (uart_d) begin
            check_val("urx_rdn", rdn_lo, 2);
            check_val("urx_release", rdn_last + 1, stall);
            check_val("urx_dout", 32'(dout), 32'({8'h00, rx}));
            last_load = {8'h00, rx};
        end else if (wr) begin
            check_val("st_stall", stall, W + 3);
            check_val("st_we", we_lo, W + 1);
            check_val("st_dout", 32'(dout), 32'(last_load));
            ref_mem[addr[7:0]] = wdata;
            written.push_back(addr);
        end else begin
            check_val("ld_stall", stall, W + 2);
            check_val("ld_oe", oe_lo, W + 1);
            check_val("ld_dout", 32'(dout), 32'(ref_mem[addr[7:0]]));
            last_load = ref_mem[addr[7:0]];
        end
        @(posedge Clk); #1;
        MemWrite2  = 1'b0;
        MemRead2   = 1'b0;
        data_ready = 1'b0;
        tbre       = 1'b1;
        tsre       = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        total      = 0;
        bad        = 0;
        last_load  = 16'h0000;
        Rst        = 1'b0;
        Result2    = 16'h0000;
        DataIn2    = 16'h0000;
        MemWrite2  = 1'b0;
        MemRead2   = 1'b0;
        data_ready = 1'b0;
        tbre       = 1'b1;
        tsre       = 1'b1;
        rx_byte    = 8'h00;
        rx_hi      = 8'h00;
        tb_pull    = 1'b1;
        #7;
        check_val("rst_stall", 32'(MemStall), 32'd0);
        check_val("rst_dout", 32'(DataOut2), 32'd0);
        check_val("rst_en", 32'(Ram1_EN), 32'd1);
        check_val("rst_oe", 32'(Ram1_OE), 32'd1);
        check_val("rst_we", 32'(Ram1_WE), 32'd1);
        check_val("rst_addr", 32'(Ram1_address), 32'd0);
        check_val("rst_rdn", 32'(rdn), 32'd1);
        check_val("rst_wrn", 32'(wrn), 32'd1);
        check_val("rst_bus", 32'(Ram1_data), 32'hA5C3);
        tb_pull = 1'b0;
        @(posedge Clk); #1;
        Rst = 1'b1;

        access(1'b1, 1'b0, 16'h4000, 16'h1234, 0, 0, 8'h00);
        access(1'b0, 1'b1, 16'h4000, 16'h0000, 0, 0, 8'h00);
        data_ready = 1'b1;
        access(1'b0, 1'b1, 16'hBF01, 16'h0000, 0, 0, 8'h00);
        access(1'b1, 1'b0, 16'hBF00, 16'h0041, 0, 5, 8'h00);
        access(1'b0, 1'b1, 16'hBF00, 16'h0000, 4, 0, 8'h5A);
        access(1'b1, 1'b1, 16'h4001, 16'hC0DE, 0, 0, 8'h00);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 5);
            a    = 16'h4000 | 16'($urandom_range(0, 127));
            if (kind == 2 && written.size() == 0) kind = 0;
            case (kind)
                0, 1: access(1'b1, 1'($urandom_range(0, 1)), a, 16'($urandom), 0, 0, 8'h00);
                2: begin
                    a = written[$urandom_range(0, written.size() - 1)];
                    access(1'b0, 1'b1, a, 16'h0000, 0, 0, 8'h00);
                end
                3: begin
                    data_ready = 1'($urandom);
                    tbre       = 1'($urandom);
                    tsre       = 1'($urandom);
                    access(1'b0, 1'b1, 16'hBF01, 16'h0000, 0, 0, 8'h00);
                end
                4: access(1'b1, 1'($urandom_range(0, 1)), 16'hBF00, 16'($urandom), 0,
                          $urandom_range(0, 6), 8'h00);
                default: access(1'b0, 1'b1, 16'hBF00, 16'h0000, $urandom_range(0, 6), 0,
                                8'($urandom));
            endcase
        end

        @(posedge Clk); #1;
        MemWrite2 = 1'b1;
        Result2   = 16'h40F0;
        DataIn2   = 16'hBEEF;
        @(posedge Clk); #1;
        @(negedge Clk);
        check_val("rst_mid_we", 32'(Ram1_WE), 32'd0);
        #2;
        Rst       = 1'b0;
        MemWrite2 = 1'b0;
        tb_pull   = 1'b1;
        #1;
        check_val("arst_we", 32'(Ram1_WE), 32'd1);
        check_val("arst_en", 32'(Ram1_EN), 32'd1);
        check_val("arst_wrn", 32'(wrn), 32'd1);
        check_val("arst_stall", 32'(MemStall), 32'd0);
        check_val("arst_bus", 32'(Ram1_data), 32'hA5C3);
        check_val("arst_dout", 32'(DataOut2), 32'd0);
        last_load = 16'h0000;
        tb_pull   = 1'b0;
        @(posedge Clk); #1;
        Rst = 1'b1;
        @(negedge Clk);
        check_val("post_rst_stall", 32'(MemStall), 32'd0);
        check_val("post_rst_en", 32'(Ram1_EN), 32'd1);
        access(1'b1, 1'b0, 16'h4002, 16'h5AA5, 0, 0, 8'h00);
        access(1'b0, 1'b1, 16'h4002, 16'h0000, 0, 0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
